// File: rtl/strhw_msg_ctrl.sv
// rtl/strhw_msg_ctrl.sv - Streebog message-level controller; optional stage watchdog via STRHW_MSG_CTRL_TIMEOUT_EN
package strhw_msg_ctrl_pkg;
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

module strhw_msg_ctrl
    import strhw_msg_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter bit          HASH256_OUT_LOW = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         trg_i,
    input  logic         hash_size_i,
    output state_t       state_o,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic         blk_last_i,
    input  logic [511:0] block_i,
    input  logic [6:0]   block_size_i,
    output logic [511:0] hash_o,
    output logic         err_o,
    output logic         st_trg_o,
    output logic [1:0]   st_op_o,
    input  state_t       st_state_i,
    output logic [511:0] st_block_o,
    output logic [9:0]   st_block_size_o,
    output logic [511:0] st_sigma_o,
    output logic [511:0] st_n_o,
    output logic [511:0] st_h_o,
    input  logic [511:0] st_sigma_new_i,
    input  logic [511:0] st_n_new_i,
    input  logic [511:0] st_h_new_i
);

    localparam logic [1:0] OP_COMPRESS = 2'd0;
    localparam logic [1:0] OP_FIN_N    = 2'd1;
    localparam logic [1:0] OP_FIN_S    = 2'd2;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_ACCEPT,
        S_RUN,
        S_PAD,
        S_FIN_N,
        S_DONE,
        S_ERR
    } fsm_t;

    fsm_t         state_q, state_d;
    logic         hs, blk_bad, st_done, timeout;
    logic [511:0] pad_block;
    logic [9:0]   pad_size;

    logic [1:0]   op_q;
    logic         trg_q, last_q, full_q, mode256_q, err_q;
    logic [511:0] h_q, n_q, sigma_q, blk_q, hash_q;
    logic [9:0]   size_q;

    function automatic logic [511:0] digest(input logic [511:0] h, input logic m256);
        if (!m256)
            digest = h;
        else if (HASH256_OUT_LOW)
            digest = {256'h0, h[511:256]};
        else
            digest = {h[511:256], 256'h0};
    endfunction

    assign hs      = blk_valid_i && (state_q == S_ACCEPT);
    assign blk_bad = (block_size_i > 7'd64) || ((block_size_i != 7'd64) && !blk_last_i);
    assign st_done = (state_q == S_RUN) && (st_state_i == DONE);

    // Byte b of a short block carries the 0x01 marker; everything above it is zero.
    always_comb begin
        pad_block = '0;
        for (int k = 0; k < 64; k++) begin
            if (k < int'(block_size_i))
                pad_block[8*k +: 8] = block_i[8*k +: 8];
            else if (k == int'(block_size_i))
                pad_block[8*k +: 8] = 8'h01;
        end
    end

    assign pad_size = {block_size_i, 3'b000};

`ifdef STRHW_MSG_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_q;

    // Counter holds the number of cycles elapsed since the last stage start.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            wd_cnt_q <= '0;
        else if (trg_q)
            wd_cnt_q <= CNT_W'(1);
        else if (state_q == S_RUN)
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end

    assign timeout = (state_q == S_RUN) && !trg_q && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_CLEAR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR:  if (trg_i) state_d = S_ACCEPT;
            S_ACCEPT: if (hs) state_d = blk_bad ? S_ERR : S_RUN;
            S_RUN: begin
                if (st_done) begin
                    case (op_q)
                        OP_COMPRESS: begin
                            if (!last_q)
                                state_d = S_ACCEPT;
                            else if (full_q)
                                state_d = S_PAD;
                            else
                                state_d = S_FIN_N;
                        end
                        OP_FIN_N: state_d = S_FIN_N;
                        default:  state_d = S_DONE;
                    endcase
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_PAD:    state_d = S_RUN;
            S_FIN_N:  state_d = S_RUN;
            S_DONE:   if (trg_i) state_d = S_ACCEPT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trg_q     <= 1'b0;
            op_q      <= OP_COMPRESS;
            last_q    <= 1'b0;
            full_q    <= 1'b0;
            mode256_q <= 1'b0;
            err_q     <= 1'b0;
            h_q       <= '0;
            n_q       <= '0;
            sigma_q   <= '0;
            blk_q     <= '0;
            size_q    <= '0;
            hash_q    <= '0;
        end else begin
            trg_q <= 1'b0;
            case (state_q)
                S_CLEAR, S_DONE: begin
                    if (trg_i) begin
                        mode256_q <= hash_size_i;
                        h_q       <= hash_size_i ? {64{8'h01}} : 512'h0;
                        n_q       <= '0;
                        sigma_q   <= '0;
                        hash_q    <= '0;
                        err_q     <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (hs) begin
                        if (blk_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            blk_q  <= pad_block;
                            size_q <= pad_size;
                            op_q   <= OP_COMPRESS;
                            last_q <= blk_last_i;
                            full_q <= (block_size_i == 7'd64);
                            trg_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (st_done) begin
                        h_q <= st_h_new_i;
                        if (op_q == OP_COMPRESS) begin
                            n_q     <= st_n_new_i;
                            sigma_q <= st_sigma_new_i;
                        end
                        // A full final block still needs the synthetic padding-only compression.
                        if (state_d == S_PAD) begin
                            blk_q  <= 512'h1;
                            size_q <= '0;
                            full_q <= 1'b0;
                            op_q   <= OP_COMPRESS;
                            trg_q  <= 1'b1;
                        end
                        if (state_d == S_FIN_N) begin
                            op_q  <= (op_q == OP_COMPRESS) ? OP_FIN_N : OP_FIN_S;
                            trg_q <= 1'b1;
                        end
                        if (state_d == S_DONE)
                            hash_q <= digest(st_h_new_i, mode256_q);
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_o = CLEAR;
        case (state_q)
            S_ACCEPT:              state_o = READY;
            S_RUN, S_PAD, S_FIN_N: state_o = BUSY;
            S_DONE:                state_o = DONE;
            default:               state_o = CLEAR;
        endcase
    end

    assign blk_ready_o     = (state_q == S_ACCEPT);
    assign st_trg_o        = trg_q;
    assign st_op_o         = op_q;
    assign st_block_o      = blk_q;
    assign st_block_size_o = size_q;
    assign st_sigma_o      = sigma_q;
    assign st_n_o          = n_q;
    assign st_h_o          = h_q;
    assign hash_o          = hash_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_strhw_msg_ctrl.sv
// tb/tb_strhw_msg_ctrl.sv - scoreboard testbench for strhw_msg_ctrl with a behavioural stage stub
module tb_strhw_msg_ctrl;
    import strhw_msg_ctrl_pkg::*;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_i, trg_i, hash_size_i;
    state_t       state_o;
    logic         blk_valid_i, blk_ready_o, blk_last_i;
    logic [511:0] block_i;
    logic [6:0]   block_size_i;
    logic [511:0] hash_o;
    logic         err_o, st_trg_o;
    logic [1:0]   st_op_o;
    state_t       st_state_i;
    logic [511:0] st_block_o;
    logic [9:0]   st_block_size_o;
    logic [511:0] st_sigma_o, st_n_o, st_h_o;
    logic [511:0] st_sigma_new_i, st_n_new_i, st_h_new_i;

    always #5 clk = ~clk;

    strhw_msg_ctrl #(.TIMEOUT_CYCLES(TO), .HASH256_OUT_LOW(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i), .trg_i(trg_i), .hash_size_i(hash_size_i),
        .state_o(state_o), .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
        .blk_last_i(blk_last_i), .block_i(block_i), .block_size_i(block_size_i),
        .hash_o(hash_o), .err_o(err_o), .st_trg_o(st_trg_o), .st_op_o(st_op_o),
        .st_state_i(st_state_i), .st_block_o(st_block_o), .st_block_size_o(st_block_size_o),
        .st_sigma_o(st_sigma_o), .st_n_o(st_n_o), .st_h_o(st_h_o),
        .st_sigma_new_i(st_sigma_new_i), .st_n_new_i(st_n_new_i), .st_h_new_i(st_h_new_i)
    );

    // Stage stub: DONE stub_lat cycles after st_trg_o, results derived from the presented state.
    bit       stub_en, stub_hmode;
    int       stub_lat;
    logic [7:0] trg_d;

    always @(posedge clk) begin
        if (rst_i) trg_d <= '0;
        else       trg_d <= {trg_d[6:0], st_trg_o};
    end

    assign st_state_i     = (stub_en && trg_d[stub_lat-1]) ? DONE : BUSY;
    assign st_h_new_i     = stub_hmode ? {{256{1'b1}}, 256'h0} : st_h_o + 512'd1;
    assign st_n_new_i     = st_n_o + 512'(st_block_size_o);
    assign st_sigma_new_i = st_sigma_o ^ st_block_o;

    typedef struct {
        bit           is_done;
        logic [1:0]   op;
        bit           chk_blk;
        logic [511:0] blk;
        logic [9:0]   size;
        logic [511:0] h;
        logic [511:0] hash;
        logic [511:0] n;
        logic [511:0] sig;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   hs_cnt  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push_trg(input logic [1:0] op, input bit cb, input logic [511:0] blk,
                            input logic [9:0] size, input logic [511:0] h);
        exp_t e;
        e = '{default: '0};
        e.op = op; e.chk_blk = cb; e.blk = blk; e.size = size; e.h = h;
        sb.push_back(e);
    endtask

    task automatic push_done(input logic [511:0] hash, input logic [511:0] n, input logic [511:0] sig);
        exp_t e;
        e = '{default: '0};
        e.is_done = 1'b1; e.hash = hash; e.n = n; e.sig = sig;
        sb.push_back(e);
    endtask

    // Monitor: every stage start and every entry into DONE consumes one scoreboard entry.
    initial begin
        state_t prev;
        exp_t   e;
        prev = CLEAR;
        forever begin
            @(negedge clk);
            if (blk_valid_i && blk_ready_o) hs_cnt++;
            if (st_trg_o) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_trg", {510'h0, st_op_o}, 512'h3);
                end else begin
                    e = sb.pop_front();
                    chk("trg_kind", {511'h0, e.is_done}, 512'h0);
                    chk("trg_op", {510'h0, st_op_o}, {510'h0, e.op});
                    if (e.chk_blk) begin
                        chk("trg_block", st_block_o, e.blk);
                        chk("trg_size", {502'h0, st_block_size_o}, {502'h0, e.size});
                    end
                    chk("trg_h", st_h_o, e.h);
                end
            end
            if (state_o == DONE && prev != DONE) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", {510'h0, state_o}, 512'h0);
                end else begin
                    e = sb.pop_front();
                    chk("done_kind", {511'h0, e.is_done}, 512'h1);
                    chk("done_hash", hash_o, e.hash);
                    chk("done_n", st_n_o, e.n);
                    chk("done_sigma", st_sigma_o, e.sig);
                end
            end
            prev = state_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit sz);
        trg_i = 1'b1; hash_size_i = sz;
        tick();
        trg_i = 1'b0;
    endtask

    task automatic send(input logic [511:0] d, input int sz, input bit last, input bit keep);
        blk_valid_i = 1'b1; block_i = d; block_size_i = 7'(sz); blk_last_i = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (blk_ready_o) break;
        end
        if (!blk_ready_o) chk("hs_wait", {511'h0, blk_ready_o}, 512'h1);
        tick();
        if (!keep) blk_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (state_o == DONE) break;
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_state"}, {510'h0, state_o}, {510'h0, CLEAR});
        chk({name, "_wide"}, hash_o | st_block_o | st_sigma_o | st_n_o | st_h_o, 512'h0);
        chk({name, "_narrow"}, {497'h0, st_block_size_o, st_op_o, st_trg_o, err_o, blk_ready_o}, 512'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        logic [511:0] d1, p1, pf, h1, hf, a, b, bp;
        rst_i = 1'b1; trg_i = 1'b0; hash_size_i = 1'b0; blk_valid_i = 1'b0;
        blk_last_i = 1'b0; block_i = '0; block_size_i = '0;
        stub_en = 1'b1; stub_hmode = 1'b0; stub_lat = 1;
        d1 = {{61{8'hEE}}, 24'hCCBBAA};
        p1 = 512'h01CCBBAA;
        pf = {64{8'hA5}};
        h1 = {64{8'h01}};
        hf = {{256{1'b1}}, 256'h0};
        a  = {64{8'h11}};
        b  = {{54{8'h77}}, 80'h00112233445566778899};
        bp = 512'h0100112233445566778899;

        tick(); tick();
        @(negedge clk);
        chk_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Partial last block, b = 3, stage latency 1.
        start(1'b0);
        push_trg(2'd0, 1'b1, p1, 10'd24, 512'd0);
        push_trg(2'd1, 1'b0, '0, '0, 512'd1);
        push_trg(2'd2, 1'b0, '0, '0, 512'd2);
        push_done(512'd3, 512'd24, p1);
        send(d1, 3, 1'b1, 1'b0);
        wait_done(k);
        chk("lat_partial_L1", 512'(k), 512'd7);
        tick(); tick();
        chk("sb_empty_partial", 512'(sb.size()), 512'd0);

        // Full last block, stage latency 3: synthetic padding compression appears.
        stub_lat = 3;
        start(1'b0);
        push_trg(2'd0, 1'b1, pf, 10'd512, 512'd0);
        push_trg(2'd0, 1'b1, 512'h1, 10'd0, 512'd1);
        push_trg(2'd1, 1'b0, '0, '0, 512'd2);
        push_trg(2'd2, 1'b0, '0, '0, 512'd3);
        push_done(512'd4, 512'd512, pf ^ 512'h1);
        send(pf, 64, 1'b1, 1'b0);
        wait_done(k);
        chk("lat_full_L3", 512'(k), 512'd17);
        tick(); tick();
        chk("sb_empty_full", 512'(sb.size()), 512'd0);

        // 256-bit mode, empty last block (b = 0).
        stub_lat = 2; stub_hmode = 1'b1;
        start(1'b1);
        push_trg(2'd0, 1'b1, 512'h1, 10'd0, h1);
        push_trg(2'd1, 1'b0, '0, '0, hf);
        push_trg(2'd2, 1'b0, '0, '0, hf);
        push_done(hf, 512'd0, 512'h1);
        send(d1, 0, 1'b1, 1'b0);
        wait_done(k);
        tick(); tick();
        chk("sb_empty_256", 512'(sb.size()), 512'd0);
        stub_hmode = 1'b0;

        // Two blocks with blk_valid_i held high throughout.
        start(1'b0);
        hs_cnt = 0;
        push_trg(2'd0, 1'b1, a, 10'd512, 512'd0);
        push_trg(2'd0, 1'b1, bp, 10'd80, 512'd1);
        push_trg(2'd1, 1'b0, '0, '0, 512'd2);
        push_trg(2'd2, 1'b0, '0, '0, 512'd3);
        push_done(512'd4, 512'd592, a ^ bp);
        send(a, 64, 1'b0, 1'b1);
        send(b, 10, 1'b1, 1'b1);
        wait_done(k);
        tick(); tick();
        chk("hs_count_backpressure", 512'(hs_cnt), 512'd2);
        chk("sb_empty_multi", 512'(sb.size()), 512'd0);
        blk_valid_i = 1'b0;

        // Oversized block: error, no stage start, trg ignored until reset.
        start(1'b0);
        send(d1, 65, 1'b1, 1'b0);
        repeat (4) tick();
        chk("err_b65", {511'h0, err_o}, 512'h1);
        chk("state_err_b65", {510'h0, state_o}, {510'h0, CLEAR});
        start(1'b0);
        repeat (3) tick();
        chk("trg_ignored_in_err", {511'h0, blk_ready_o}, 512'h0);
        chk("err_sticky", {511'h0, err_o}, 512'h1);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("err_cleared_by_rst", {511'h0, err_o}, 512'h0);

        // Short block without last flag.
        start(1'b0);
        send(d1, 10, 1'b0, 1'b0);
        repeat (3) tick();
        chk("err_short_notlast", {511'h0, err_o}, 512'h1);
        rst_i = 1'b1; tick(); rst_i = 1'b0;

        // Stage never answers.
        stub_en = 1'b0;
        start(1'b0);
        push_trg(2'd0, 1'b1, pf, 10'd512, 512'd0);
        send(pf, 64, 1'b0, 1'b0);
        @(negedge clk);
        chk("to_trg_seen", {511'h0, st_trg_o}, 512'h1);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            k++;
            if (err_o) break;
        end
`ifdef STRHW_MSG_CTRL_TIMEOUT_EN
        chk("timeout_cycles", 512'(k), 512'(TO));
`else
        chk("no_timeout_err", {511'h0, err_o}, 512'h0);
`endif
        chk("sb_empty_timeout", 512'(sb.size()), 512'd0);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        stub_en = 1'b1;

        // Reset while FIN_N is in flight, then a clean run.
        stub_lat = 3;
        start(1'b0);
        push_trg(2'd0, 1'b1, p1, 10'd24, 512'd0);
        push_trg(2'd1, 1'b0, '0, '0, 512'd1);
        send(d1, 3, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("fin_n_reached", {510'h0, st_op_o}, 512'd1);
        rst_i = 1'b1;
        sb.delete();
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        tick(); tick(); tick(); tick();
        chk("midreset_stale_done_ignored", {510'h0, state_o}, {510'h0, CLEAR});
        start(1'b0);
        push_trg(2'd0, 1'b1, p1, 10'd24, 512'd0);
        push_trg(2'd1, 1'b0, '0, '0, 512'd1);
        push_trg(2'd2, 1'b0, '0, '0, 512'd2);
        push_done(512'd3, 512'd24, p1);
        send(d1, 3, 1'b1, 1'b0);
        wait_done(k);
        chk("lat_partial_L3", 512'(k), 512'd13);
        tick(); tick();
        chk("sb_empty_final", 512'(sb.size()), 512'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/strhw_msg_ctrl.md
# strhw_msg_ctrl

Parametrised message-level controller for the Streebog (GOST 34.11-2018) core, sitting between the initiator and the stage block.
- Accepts a stream of message blocks through a valid/ready handshake.
- Pads the final block and selects the 256- or 512-bit IV.
- Sequences the stage block through compression and the two finalisation passes, g_0(h,N) and g_0(h,Sigma).
- Holds the algorithm state (h, N, Sigma) and presents the hash.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: stage watchdog limit in cycles; used only with the macro under Configuration.
- HASH256_OUT_LOW, 0: in 256-bit mode, 1 places the digest in hash_o[255:0], 0 places it in hash_o[511:256]. The remaining half is zero in both cases.

Ports:
- clk_i  in  1  clock; everything is synchronous to the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- trg_i  in  1  start pulse; initialises a new hash. Honoured only in CLEAR or DONE.
- hash_size_i  in  1  sampled on trg_i. 0 selects 512-bit, 1 selects 256-bit.
- state_o  out  state_t  coarse status: CLEAR, READY, BUSY or DONE.
- blk_valid_i  in  1  block offered.
- blk_ready_o  out  1  block accepted when blk_valid_i and blk_ready_o are both 1.
- blk_last_i  in  1  the offered block is the final block.
- block_i  in  512  block data; byte k is block_i[8k+7:8k].
- block_size_i  in  7  valid bytes, 0..64. Any value other than 64 is legal only with blk_last_i=1.
- hash_o  out  512  digest; valid while state_o=DONE.
- err_o  out  1  sticky protocol/watchdog error.
- st_trg_o  out  1  one-cycle stage start.
- st_op_o  out  2  stage operation: 0 COMPRESS, 1 FIN_N, 2 FIN_S.
- st_state_i  in  state_t  stage status; DONE for one cycle means the results are valid.
- st_block_o  out  512  padded block to the stage.
- st_block_size_o  out  10  block length in bits, 0..512.
- st_sigma_o, st_n_o, st_h_o  out  512 each  current Sigma, N and h.
- st_sigma_new_i, st_n_new_i, st_h_new_i  in  512 each  stage results.

## Operation
- Internal FSM states:
  - S_CLEAR → S_ACCEPT on trg_i.
  - S_ACCEPT → S_RUN on a handshake.
  - S_RUN → S_ACCEPT, S_PAD, S_FIN_N or S_DONE on stage DONE, selected by the sequencing rules below.
  - S_PAD → S_RUN.
  - S_FIN_N → S_RUN.
  - S_DONE → S_ACCEPT on trg_i.
  - S_ERR → S_CLEAR only through rst_i.
- state_o mapping: S_CLEAR gives CLEAR; S_ACCEPT gives READY; S_RUN, S_PAD and S_FIN_N give BUSY; S_DONE gives DONE; S_ERR gives CLEAR.
- Initialisation on trg_i:
  - h = 512'h0 in 512-bit mode, or {64{8'h01}} in 256-bit mode.
  - N = 0 and Sigma = 0.
  - hash_o and err_o are cleared.
- Padding, for block_size_i = b < 64:
  - bytes 0..b-1 are taken from block_i;
  - byte b is 8'h01;
  - bytes above b are zero;
  - st_block_size_o = 8·b.
- A full block (b = 64) passes through unchanged with st_block_size_o = 512.
- Sequencing:
  - Every accepted block issues COMPRESS.
  - A non-last block returns to S_ACCEPT.
  - A last block with b < 64 proceeds to FIN_N, then FIN_S.
  - A last block with b = 64 first issues a synthetic COMPRESS through S_PAD: block 512'h1, size 0. It then proceeds to FIN_N and FIN_S.
- Result latching: on each stage DONE, h, N and Sigma are loaded from the st_*_new_i inputs. FIN_N and FIN_S update only h.
- Output: after FIN_S, hash_o = h in 512-bit mode. In 256-bit mode hash_o holds h[511:256], placed according to HASH256_OUT_LOW.
- Protocol error: block_size_i > 64, or b < 64 with blk_last_i = 0, on a handshake sets err_o and moves to S_ERR. No stage operation is issued.
- Ignored events:
  - trg_i while BUSY or READY is ignored. A restart requires DONE or a reset.
  - A stage DONE outside S_RUN is ignored.

## Timing
- Reset values: state_o = CLEAR; every other output, hash_o included, is zero.
- blk_ready_o = 1 only in S_ACCEPT. It drops in the cycle after a handshake.
- st_trg_o pulses for one cycle, 1 cycle after the handshake or the internal step.
- st_block_o, st_block_size_o, st_op_o, st_sigma_o, st_n_o and st_h_o are stable from st_trg_o until stage DONE.
- Stage DONE in cycle t gives updated st_* and the next st_trg_o (or blk_ready_o) in cycle t+1.
- With stage latency L, a final partial block reaches state_o = DONE in 3·(L+1)+1 cycles after the handshake. A final full block takes 4·(L+1)+1 cycles.
- A stage DONE coincident with st_trg_o is impossible by construction. If st_state_i reads DONE in the cycle after st_trg_o, it is accepted.
- rst_i has priority over everything. A reset mid-operation returns to CLEAR in the next cycle, and any in-flight stage result is discarded.

## Configuration
- STRHW_MSG_CTRL_TIMEOUT_EN defined:
  - a watchdog counter restarts at every st_trg_o;
  - if it reaches TIMEOUT_CYCLES without stage DONE, err_o is set and the FSM moves to S_ERR.
- Not defined: no counter exists; the controller waits indefinitely and err_o reflects protocol errors only.

## Test plan
- Pad check: trg_i with hash_size_i = 0, then one last block with b = 3 and block_i = 24'hCCBBAA → st_block_o = 32'h01CCBBAA (upper bits 0), st_block_size_o = 24, then st_op_o = 0, 1, 2 in turn, then DONE.
- Full last block: trg_i, then one last block with b = 64 → four st_trg_o pulses with ops 0, 0, 1, 2. The second COMPRESS carries block 512'h1 and size 0.
- 256-bit mode:
  - after trg_i with hash_size_i = 1, st_h_o = {64{8'h01}} at the first COMPRESS;
  - with a stub returning h_new = 512'hF…F0…0 (upper half all ones), hash_o = {256'hF…F, 256'h0}.
- Back-pressure and illegal-block: blk_valid_i is held through BUSY and only one handshake occurs per COMPRESS; b = 65 → err_o = 1, no st_trg_o, and state stays CLEAR until rst_i.
- Timeout, with the macro defined and TIMEOUT_CYCLES = 16: the stage never answers → err_o rises exactly 16 cycles after st_trg_o. Without the macro, err_o stays 0.
- Reset in the middle of FIN_N → one cycle later state_o = CLEAR and all outputs are 0. A new trg_i then completes normally.
